neuron_lut_prog: RTL and testbench

NEURON_LUT_PROG -- requirements
Module: neuron_lut_prog

---
 rtl/neuron_lut_pkg.sv | 21 ++
 rtl/neuron_lut_prog_if.sv | 28 ++
 rtl/neuron_lut_ram.sv | 66 ++++++
 rtl/neuron_lut_prog.sv | 120 ++++++++++++
 tb/tb_neuron_lut_prog.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_lut_pkg.sv
// Shared definitions for the programmable neuron lookup table: controller states,
// beat geometry and helpers that size the load counter and table depth.
package neuron_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } lut_state_e;

    localparam int ENTRIES_PER_BEAT = 4;

    function automatic int beat_count(input int in_bits);
        return (32'sd1 <<< in_bits) / ENTRIES_PER_BEAT;
    endfunction

    function automatic int beat_width(input int in_bits);
        return in_bits - 32'sd2;
    endfunction

endpackage

// File: rtl/neuron_lut_prog_if.sv
// Configuration-load and lookup handshake bundle for neuron_lut_prog.
// The master modport is the driving agent, the slave modport is the LUT block.
interface neuron_lut_prog_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
);
    logic                                              cfg_start;
    logic                                              cfg_valid;
    logic [neuron_lut_pkg::ENTRIES_PER_BEAT*OUT_BITS-1:0] cfg_data;
    logic                                              cfg_ready;
    logic                                              loaded;
    logic                                              in_valid;
    logic [IN_BITS-1:0]                                in_data;
    logic                                              in_ready;
    logic                                              out_valid;
    logic [OUT_BITS-1:0]                               out_data;
    logic                                              out_ready;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        input  cfg_ready, loaded, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        output cfg_ready, loaded, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/neuron_lut_ram.sv
// Distributed-RAM lookup table: one 4-entry-wide write port, one registered lookup
// read port and, with NEURON_LUT_READBACK_EN, a registered readback port.
module neuron_lut_ram
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    localparam int BEAT_W  = beat_width(IN_BITS),
    localparam int DEPTH   = beat_count(IN_BITS) * ENTRIES_PER_BEAT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [BEAT_W-1:0]                    wr_beat,
    input  logic [ENTRIES_PER_BEAT*OUT_BITS-1:0] wr_data,
    input  logic                                 rd_en,
    input  logic [IN_BITS-1:0]                   rd_addr,
    output logic [OUT_BITS-1:0]                  rd_data
`ifdef NEURON_LUT_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]                   rb_addr,
    output logic [OUT_BITS-1:0]                  rb_data
`endif
);

    logic [OUT_BITS-1:0] mem [0:DEPTH-1];
    logic [OUT_BITS-1:0] rd_data_r;

    // Table storage; deliberately not reset so it maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < ENTRIES_PER_BEAT; i++) begin
                mem[{wr_beat, i[1:0]}] <= wr_data[i*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Lookup result register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {OUT_BITS{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

`ifdef NEURON_LUT_READBACK_EN
    logic [OUT_BITS-1:0] rb_data_r;

    // Readback register, free-running in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_data_r <= {OUT_BITS{1'b0}};
        end else begin
            rb_data_r <= mem[rb_addr];
        end
    end

    assign rb_data = rb_data_r;
`endif

endmodule

// File: rtl/neuron_lut_prog.sv
// Programmable neuron lookup table: loads the table in 4-entry beats, then serves
// registered lookups with backpressure. Optional readback port: NEURON_LUT_READBACK_EN.
module neuron_lut_prog
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    neuron_lut_prog_if.slave    bus
`ifdef NEURON_LUT_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]  rb_addr,
    output logic [OUT_BITS-1:0] rb_data
`endif
);

    localparam int BEAT_W = beat_width(IN_BITS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(beat_count(IN_BITS) - 32'sd1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(32'sd1);

    lut_state_e          state_r;
    lut_state_e          state_s;
    logic [BEAT_W-1:0]   beat_cnt_r;
    logic                loaded_r;
    logic                out_valid_r;
    logic                cfg_ready_s;
    logic                in_ready_s;
    logic                beat_fire_s;
    logic                last_beat_s;
    logic                lookup_fire_s;
    logic [OUT_BITS-1:0] rd_data_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; cfg_start restarts a load from any state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cfg_start) state_s = ST_LOAD;
                else               state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (bus.cfg_start)     state_s = ST_LOAD;
                else if (last_beat_s)  state_s = ST_RUN;
                else                   state_s = ST_LOAD;
            end
            ST_RUN: begin
                if (bus.cfg_start) state_s = ST_LOAD;
                else               state_s = ST_RUN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake decode; a coincident cfg_start swallows any beat or lookup.
    always_comb begin
        cfg_ready_s   = (state_r == ST_LOAD);
        in_ready_s    = (state_r == ST_RUN) && (!out_valid_r || bus.out_ready);
        beat_fire_s   = cfg_ready_s && bus.cfg_valid && !bus.cfg_start;
        last_beat_s   = beat_fire_s && (beat_cnt_r == LAST_BEAT);
        lookup_fire_s = bus.in_valid && in_ready_s && !bus.cfg_start;
    end

    // Beat counter, loaded flag and result-valid tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r  <= {BEAT_W{1'b0}};
            loaded_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (bus.cfg_start) begin
            beat_cnt_r  <= {BEAT_W{1'b0}};
            loaded_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (beat_fire_s) beat_cnt_r <= beat_cnt_r + BEAT_ONE;
            else             beat_cnt_r <= beat_cnt_r;
            if (last_beat_s) loaded_r <= 1'b1;
            else             loaded_r <= loaded_r;
            if (lookup_fire_s)      out_valid_r <= 1'b1;
            else if (bus.out_ready) out_valid_r <= 1'b0;
            else                    out_valid_r <= out_valid_r;
        end
    end

    neuron_lut_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (beat_fire_s),
        .wr_beat  (beat_cnt_r),
        .wr_data  (bus.cfg_data),
        .rd_en    (lookup_fire_s),
        .rd_addr  (bus.in_data),
        .rd_data  (rd_data_s)
`ifdef NEURON_LUT_READBACK_EN
        ,
        .rb_addr  (rb_addr),
        .rb_data  (rb_data)
`endif
    );

    assign bus.cfg_ready = cfg_ready_s;
    assign bus.loaded    = loaded_r;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = rd_data_s;

endmodule

// File: tb/tb_neuron_lut_prog.sv
// Directed + randomized bench for neuron_lut_prog; expected values come from a
// 256-entry table model updated from the beat layout and a one-deep result model.
module tb_neuron_lut_prog;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_lut_prog_if #(.IN_BITS(8), .OUT_BITS(2)) bus ();

`ifdef NEURON_LUT_READBACK_EN
    logic [7:0] rb_addr = 8'h00;
    logic [1:0] rb_data;
`endif

    neuron_lut_prog #(.IN_BITS(8), .OUT_BITS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef NEURON_LUT_READBACK_EN
        ,
        .rb_addr (rb_addr),
        .rb_data (rb_data)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [1:0] tbl [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, bus.cfg_ready, 0);
        check({tag, "_loaded"},    bus.loaded,    0);
        check({tag, "_in_ready"},  bus.in_ready,  0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"},  bus.out_data,  0);
`ifdef NEURON_LUT_READBACK_EN
        check({tag, "_rb_data"},   rb_data,       0);
`endif
    endtask

    // One accepted beat k: entries 4k..4k+3, lowest entry in the low bits.
    task automatic send_beat(input int k, input logic [7:0] d);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        step();
        bus.cfg_valid = 1'b0;
        for (int j = 0; j < 4; j++) tbl[4*k + j] = d[2*j +: 2];
    endtask

    // mode 0: entry[a]=a[1:0]; mode 1: all 2'b01; mode 2: random
    task automatic load_beats(input int mode);
        logic [7:0] d;
        for (int k = 0; k < 64; k++) begin
            if (mode == 0)      d = 8'hE4;
            else if (mode == 1) d = 8'h55;
            else                d = 8'($urandom);
            check("load_not_yet_loaded", bus.loaded, 0);
            check("load_cfg_ready", bus.cfg_ready, 1);
            send_beat(k, d);
        end
        check("load_done_loaded", bus.loaded, 1);
        check("load_done_cfg_ready", bus.cfg_ready, 0);
        check("load_done_in_ready", bus.in_ready, 1);
    endtask

    task automatic full_load(input int mode);
        bus.out_ready = 1'b1;
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        load_beats(mode);
    endtask

    task automatic do_lookup(input logic [7:0] a);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = a;
        check("lookup_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        check("lookup_out_valid", bus.out_valid, 1);
        check("lookup_out_data", bus.out_data, tbl[a]);
    endtask

    // Random lookup traffic against a one-deep result model.
    task automatic random_traffic(input int n);
        logic       exp_ov;
        logic [1:0] exp_od;
        logic       iv, ordy, fire;
        logic [7:0] a;
        logic [7:0] ra;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        exp_ov = 1'b0;
        exp_od = 2'b00;
        ra     = 8'h00;
        for (int i = 0; i < n; i++) begin
            iv   = 1'($urandom_range(0, 1));
            a    = 8'($urandom_range(0, 255));
            ordy = ($urandom_range(0, 3) != 0);
            ra   = 8'($urandom_range(0, 255));
            bus.in_valid  = iv;
            bus.in_data   = a;
            bus.out_ready = ordy;
`ifdef NEURON_LUT_READBACK_EN
            rb_addr = ra;
`endif
            #1;
            check("rand_in_ready", bus.in_ready, {31'd0, (!exp_ov || ordy)});
            fire = iv && (!exp_ov || ordy);
            step();
            if (fire)      begin exp_ov = 1'b1; exp_od = tbl[a]; end
            else if (ordy) exp_ov = 1'b0;
            check("rand_out_valid", bus.out_valid, {31'd0, exp_ov});
            if (exp_ov) check("rand_out_data", bus.out_data, exp_od);
`ifdef NEURON_LUT_READBACK_EN
            check("rand_rb_data", rb_data, tbl[ra]);
`endif
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
    endtask

    initial begin
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // cfg_valid in IDLE is ignored
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'hFF;
        step();
        check("idle_cfg_ready", bus.cfg_ready, 0);
        check("idle_loaded", bus.loaded, 0);
        bus.cfg_valid = 1'b0;

        // Full load with entry[a]=a[1:0]
        full_load(0);
        do_lookup(8'hC7);
        check("lookup_c7", bus.out_data, 2'b11);
`ifdef NEURON_LUT_READBACK_EN
        rb_addr      = 8'h83;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h42;
        step();
        bus.in_valid = 1'b0;
        check("rb_83", rb_data, 2'b11);
        check("rb_concurrent_out_valid", bus.out_valid, 1);
        check("rb_concurrent_out_data", bus.out_data, 2'b10);
`endif

        // Backpressure: three lookups with the consumer stalled
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h00;
        check("bp_first_in_ready", bus.in_ready, 1);
        step();
        bus.in_data = 8'h03;
        for (int i = 0; i < 4; i++) begin
            check("bp_stall_in_ready", bus.in_ready, 0);
            check("bp_stall_out_valid", bus.out_valid, 1);
            check("bp_stall_out_data", bus.out_data, 2'b00);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", bus.in_ready, 1);
        step();
        check("bp_res2", bus.out_data, 2'b11);
        bus.in_data = 8'h07;
        step();
        check("bp_res3", bus.out_data, 2'b11);
        bus.in_valid = 1'b0;
        step();
        check("bp_drained", bus.out_valid, 0);

        // Random table and random traffic
        full_load(2);
        random_traffic(300);

        // Restart after beat 20, with a beat colliding with cfg_start
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        for (int k = 0; k <= 20; k++) send_beat(k, 8'($urandom));
        check("restart_loaded_mid", bus.loaded, 0);
        bus.cfg_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'hFF;
        step();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        load_beats(1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int a = 0; a < 256; a++) begin
            bus.in_data = 8'(a);
            step();
            check("restart_sweep_valid", bus.out_valid, 1);
            check("restart_sweep_data", bus.out_data, 2'b01);
        end
        bus.in_valid = 1'b0;
        step();

        // Reload from RUN with a result pending
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h05;
        step();
        bus.in_valid = 1'b0;
        check("reload_pending_valid", bus.out_valid, 1);
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("reload_out_valid", bus.out_valid, 0);
        check("reload_in_ready", bus.in_ready, 0);
        check("reload_loaded", bus.loaded, 0);
        check("reload_cfg_ready", bus.cfg_ready, 1);

        // Reset at beat 30 of that load
        for (int k = 0; k < 30; k++) send_beat(k, 8'($urandom));
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'hAA;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("midload_reset");
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_reset_cfg_ready", bus.cfg_ready, 0);
            check("post_reset_loaded", bus.loaded, 0);
        end
        bus.cfg_valid = 1'b0;

        full_load(0);
        do_lookup(8'h3A);
        do_lookup(8'hFD);
        random_traffic(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
